reg_wb_arbiter: RTL and testbench

//  Write-side front end of the 32x32 register file: merges the in-order pipeline

---
 rtl/reg_wb_arbiter_if.sv | 64 ++++++
 rtl/reg_wb_arbiter.sv | 110 +++++++++++
 tb/tb_reg_wb_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/reg_wb_arbiter_if.sv
// Register-file write-side bundle: pipeline writeback, multi-cycle results,
// write port, scoreboard. WB_FWD_EN adds the decode forwarding outputs.
interface reg_wb_arbiter_if #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int NR = 1 << AW;

  logic          pipe_we;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] pipe_data;
  logic          mc_issue;
  logic [AW-1:0] mc_issue_addr;
  logic          mc_valid;
  logic          mc_ready;
  logic [AW-1:0] mc_addr;
  logic [DW-1:0] mc_data;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] WD;
  logic          wEna;
  logic [NR-1:0] pend_mask;
  logic [CW-1:0] buf_count;
`ifdef WB_FWD_EN
  logic          fwd_valid;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;

  modport slave (
    input  pipe_we, pipe_addr, pipe_data,
    input  mc_issue, mc_issue_addr,
    input  mc_valid, mc_addr, mc_data,
    output mc_ready, write_addr, WD, wEna,
    output pend_mask, buf_count,
    output fwd_valid, fwd_addr, fwd_data
  );

  modport master (
    output pipe_we, pipe_addr, pipe_data,
    output mc_issue, mc_issue_addr,
    output mc_valid, mc_addr, mc_data,
    input  mc_ready, write_addr, WD, wEna,
    input  pend_mask, buf_count,
    input  fwd_valid, fwd_addr, fwd_data
  );
`else
  modport slave (
    input  pipe_we, pipe_addr, pipe_data,
    input  mc_issue, mc_issue_addr,
    input  mc_valid, mc_addr, mc_data,
    output mc_ready, write_addr, WD, wEna,
    output pend_mask, buf_count
  );

  modport master (
    output pipe_we, pipe_addr, pipe_data,
    output mc_issue, mc_issue_addr,
    output mc_valid, mc_addr, mc_data,
    input  mc_ready, write_addr, WD, wEna,
    input  pend_mask, buf_count
  );
`endif
endinterface

// File: rtl/reg_wb_arbiter.sv
// Register-file write arbiter: pipeline first, late results via FIFO,
// pending-write scoreboard. WB_FWD_EN enables head forwarding to decode.
module reg_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  reg_wb_arbiter_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NR = 1 << AW;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic          pipe_act, push, drain;
  logic [NR-1:0] pend, set_m, clr_m;
  logic          wena_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wd_q;

  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign pipe_act  = bus.pipe_we && (bus.pipe_addr != '0);
  assign drain     = !pipe_act && (cnt != '0);
  assign push      = bus.mc_valid && bus.mc_ready;

  assign bus.mc_ready   = cnt < CW'(DEPTH);
  assign bus.buf_count  = cnt;
  assign bus.pend_mask  = pend;
  assign bus.wEna       = wena_q;
  assign bus.write_addr = waddr_q;
  assign bus.WD         = wd_q;

`ifdef WB_FWD_EN
  assign bus.fwd_valid = (cnt != '0) && (head_addr != '0);
  assign bus.fwd_addr  = head_addr;
  assign bus.fwd_data  = head_data;
`endif

  // Scoreboard set/clear masks; r0 is never reserved
  always_comb begin
    set_m = '0;
    clr_m = '0;
    if (bus.mc_issue && (bus.mc_issue_addr != '0))
      set_m[bus.mc_issue_addr] = 1'b1;
    if (drain)
      clr_m[head_addr] = 1'b1;
  end

  // Result storage, written at the tail on accept
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= bus.mc_addr;
      data_q[wr_ptr] <= bus.mc_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (drain) rd_ptr <= rd_ptr + PW'(1);
      unique case (1'b1)
        push && !drain: cnt <= cnt + CW'(1);
        drain && !push: cnt <= cnt - CW'(1);
        default:        cnt <= cnt;
      endcase
    end
  end

  // Registered write port: pipeline wins, else buffer head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wena_q  <= 1'b0;
      waddr_q <= '0;
      wd_q    <= '0;
    end else begin
      unique case (1'b1)
        pipe_act: begin
          wena_q  <= 1'b1;
          waddr_q <= bus.pipe_addr;
          wd_q    <= bus.pipe_data;
        end
        drain: begin
          wena_q  <= head_addr != '0;
          waddr_q <= head_addr;
          wd_q    <= head_data;
        end
        default: wena_q <= 1'b0;
      endcase
    end
  end

  // Pending mask: a same-cycle issue overrides the drain clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= (pend & ~clr_m) | set_m;
  end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed scenarios then random traffic,
// checked against a queue-based reference model.
module tb_reg_wb_arbiter;
  localparam int DEPTH = 2;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  ent_t        q[$];
  logic [31:0] pend_m;

  reg_wb_arbiter_if #(.DEPTH(DEPTH), .AW(5), .DW(32)) bus ();

  reg_wb_arbiter #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    bus.pipe_we = 0; bus.pipe_addr = 0; bus.pipe_data = 0;
    bus.mc_issue = 0; bus.mc_issue_addr = 0;
    bus.mc_valid = 0; bus.mc_addr = 0; bus.mc_data = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wena"}, bus.wEna, 0);
    chk({tag, "_waddr"}, bus.write_addr, 0);
    chk({tag, "_wd"}, bus.WD, 0);
    chk({tag, "_pend"}, bus.pend_mask, 0);
    chk({tag, "_cnt"}, bus.buf_count, 0);
  endtask

  task automatic cyc(input bit pwe, input logic [4:0] pa,
                     input logic [31:0] pd, input bit iss,
                     input logic [4:0] ia, input bit mv,
                     input logic [4:0] ma, input logic [31:0] md);
    ent_t        h;
    bit          act, rdy, dr, ew;
    logic [4:0]  ea;
    logic [31:0] ed;
    @(negedge clk);
    bus.pipe_we = pwe; bus.pipe_addr = pa; bus.pipe_data = pd;
    bus.mc_issue = iss; bus.mc_issue_addr = ia;
    bus.mc_valid = mv; bus.mc_addr = ma; bus.mc_data = md;
    #1;
    rdy = q.size() < DEPTH;
    chk("mc_ready", bus.mc_ready, rdy);
`ifdef WB_FWD_EN
    chk("fwd_valid", bus.fwd_valid, (q.size() > 0) && (q[0].a != 0));
    if (q.size() > 0) begin
      chk("fwd_addr", bus.fwd_addr, q[0].a);
      chk("fwd_data", bus.fwd_data, q[0].d);
    end
`endif
    act = pwe && (pa != 0);
    dr  = !act && (q.size() > 0);
    ew = 0; ea = 0; ed = 0;
    if (act) begin
      ew = 1; ea = pa; ed = pd;
    end else if (dr) begin
      h = q.pop_front();
      ew = h.a != 0; ea = h.a; ed = h.d;
      pend_m[h.a] = 1'b0;
    end
    if (mv && rdy) q.push_back('{a: ma, d: md});
    if (iss && ia != 0) pend_m[ia] = 1'b1;
    @(posedge clk);
    #1;
    chk("wEna", bus.wEna, ew);
    if (ew) begin
      chk("write_addr", bus.write_addr, ea);
      chk("WD", bus.WD, ed);
    end
    chk("pend_mask", bus.pend_mask, pend_m);
    chk("buf_count", bus.buf_count, q.size());
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    idle_in();
    pend_m = 0;
    #12;
    chk_reset("por");
    @(negedge clk);
    rst = 0;
    #1;
    chk("por_ready", bus.mc_ready, 1);

    cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    chk("t2_addr", bus.write_addr, 5);
    chk("t2_wd", bus.WD, 32'hDEADBEEF);

    cyc(0, 0, 0, 1, 9, 0, 0, 0);
    idle_cyc();
    idle_cyc();
    cyc(0, 0, 0, 0, 0, 1, 9, 32'h1234);
    chk("t3_pend_hold", bus.pend_mask[9], 1);
    chk("t3_no_bypass", bus.wEna, 0);
    idle_cyc();
    chk("t3_wena", bus.wEna, 1);
    chk("t3_addr", bus.write_addr, 9);
    chk("t3_pend_clr", bus.pend_mask[9], 0);

    cyc(1, 1, 32'h11, 0, 0, 1, 3, 32'hA0);
    cyc(1, 2, 32'h22, 0, 0, 1, 4, 32'hA1);
    cyc(1, 3, 32'h33, 0, 0, 1, 6, 32'hA2);
    chk("t4_full", bus.buf_count, 2);
    chk("t4_ready", bus.mc_ready, 0);
    cyc(1, 4, 32'h44, 0, 0, 0, 0, 0);
    idle_cyc();
    chk("t4_first", bus.write_addr, 3);
    idle_cyc();
    chk("t4_second", bus.write_addr, 4);

    cyc(1, 8, 32'h88, 0, 0, 1, 12, 32'hC0);
    cyc(1, 0, 32'hFFFF, 0, 0, 0, 0, 0);
    chk("t5_r0_drain", bus.write_addr, 12);

    cyc(0, 0, 0, 1, 7, 0, 0, 0);
    cyc(1, 2, 32'h2, 0, 0, 1, 7, 32'h77);
    cyc(0, 0, 0, 1, 7, 0, 0, 0);
    chk("t6_drain_addr", bus.write_addr, 7);
    chk("t6_pend_set_wins", bus.pend_mask[7], 1);

    cyc(1, 1, 32'h1, 0, 0, 1, 10, 32'hB0);
    cyc(1, 1, 32'h1, 0, 0, 1, 11, 32'hB1);
    @(negedge clk);
    #2 rst = 1;
    #1;
    q.delete();
    pend_m = 0;
    chk_reset("t1_rst");
    idle_in();
    @(negedge clk);
    rst = 0;
    #1;
    chk("t1_ready", bus.mc_ready, 1);

    for (int i = 0; i < 400; i++) begin
      logic [4:0] pa, ia, ma;
      pa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      ia = 5'($urandom);
      ma = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      cyc($urandom_range(0, 9) < 4, pa, $urandom,
          $urandom_range(0, 3) == 0, ia,
          $urandom_range(0, 1) == 1, ma, $urandom);
    end
    repeat (4) idle_cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
